// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, fetch handshake, parking buffer for stalled fetches and the IF/ID register.
// Define IF_PERF_CNT_EN to build the saturating stall/flush performance counters.
module if_stage #(
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              rest,
   input  logic              FrezePC,
   input  logic              FrezeIFID,
   input  logic              BranchTaken,
   input  logic [DATA_W-1:0] BranchTarget,
   output logic              IMem_Req,
   output logic [DATA_W-1:0] IMem_Addr,
   input  logic              IMem_Ready,
   input  logic [DATA_W-1:0] IMem_Data,
   output logic [DATA_W-1:0] IFID_Instr,
   output logic [DATA_W-1:0] IFID_PC,
   output logic              IFID_Valid,
   output logic [DATA_W-1:0] StallCount,
   output logic [DATA_W-1:0] FlushCount
);

   typedef enum logic {FETCH, HOLD} state_t;

   state_t            state_p0, state_d;
   logic [DATA_W-1:0] pc_p0, pc_d;
   logic [DATA_W-1:0] park_p0, park_d;
   logic [DATA_W-1:0] instr_p1, instr_d;
   logic [DATA_W-1:0] ifid_pc_p1, ifid_pc_d;
   logic              vld_p1, vld_d;
   logic              stall;
   logic [DATA_W-1:0] pc_inc;

   assign stall  = FrezePC | FrezeIFID;
   assign pc_inc = pc_p0 + DATA_W'(1);

   assign IMem_Req   = (state_p0 == FETCH) && !rest;
   assign IMem_Addr  = pc_p0;
   assign IFID_Instr = instr_p1;
   assign IFID_PC    = ifid_pc_p1;
   assign IFID_Valid = vld_p1;

   always_comb begin
      state_d   = state_p0;
      pc_d      = pc_p0;
      park_d    = park_p0;
      instr_d   = instr_p1;
      ifid_pc_d = ifid_pc_p1;
      vld_d     = vld_p1;
      if (BranchTaken) begin
         // Redirect wins over everything; the same-cycle word and any parked word are dropped.
         pc_d    = BranchTarget;
         park_d  = '0;
         instr_d = '0;
         vld_d   = 1'b0;
         state_d = FETCH;
      end else begin
         unique case (state_p0)
            FETCH: begin
               if (IMem_Ready && !stall) begin
                  instr_d   = IMem_Data;
                  ifid_pc_d = pc_inc;
                  vld_d     = 1'b1;
                  pc_d      = pc_inc;
               end else if (IMem_Ready) begin
                  park_d  = IMem_Data;
                  state_d = HOLD;
               end else if (!stall) begin
                  instr_d = '0;
                  vld_d   = 1'b0;
               end
            end
            HOLD: begin
               if (!stall) begin
                  instr_d   = park_p0;
                  ifid_pc_d = pc_inc;
                  vld_d     = 1'b1;
                  pc_d      = pc_inc;
                  state_d   = FETCH;
               end
            end
            default: state_d = FETCH;
         endcase
      end
   end

   // ---- PC / parking buffer (p0) and IF/ID register (p1) ----
   always_ff @(posedge clk) begin
      if (rest) begin
         state_p0   <= FETCH;
         pc_p0      <= '0;
         park_p0    <= '0;
         instr_p1   <= '0;
         ifid_pc_p1 <= '0;
         vld_p1     <= 1'b0;
      end else begin
         state_p0   <= state_d;
         pc_p0      <= pc_d;
         park_p0    <= park_d;
         instr_p1   <= instr_d;
         ifid_pc_p1 <= ifid_pc_d;
         vld_p1     <= vld_d;
      end
   end

`ifdef IF_PERF_CNT_EN
   logic [DATA_W-1:0] stall_cnt_p0, flush_cnt_p0;

   function automatic logic [DATA_W-1:0] sat_inc(input logic [DATA_W-1:0] v);
      return (v == {DATA_W{1'b1}}) ? v : v + DATA_W'(1);
   endfunction

   always_ff @(posedge clk) begin
      if (rest) begin
         stall_cnt_p0 <= '0;
         flush_cnt_p0 <= '0;
      end else begin
         if (stall && !BranchTaken) stall_cnt_p0 <= sat_inc(stall_cnt_p0);
         if (BranchTaken)           flush_cnt_p0 <= sat_inc(flush_cnt_p0);
      end
   end

   assign StallCount = stall_cnt_p0;
   assign FlushCount = flush_cnt_p0;
`else
   assign StallCount = '0;
   assign FlushCount = '0;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Directed testbench for if_stage; counter expectations follow whether IF_PERF_CNT_EN is defined.
module tb_if_stage;

   logic        clk = 1'b0;
   logic        rest, FrezePC, FrezeIFID, BranchTaken, IMem_Ready;
   logic [15:0] BranchTarget, IMem_Data;
   logic        IMem_Req, IFID_Valid;
   logic [15:0] IMem_Addr, IFID_Instr, IFID_PC, StallCount, FlushCount;

   int checks = 0;
   int failures = 0;

   if_stage dut (
      .clk(clk), .rest(rest), .FrezePC(FrezePC), .FrezeIFID(FrezeIFID),
      .BranchTaken(BranchTaken), .BranchTarget(BranchTarget),
      .IMem_Req(IMem_Req), .IMem_Addr(IMem_Addr), .IMem_Ready(IMem_Ready),
      .IMem_Data(IMem_Data), .IFID_Instr(IFID_Instr), .IFID_PC(IFID_PC),
      .IFID_Valid(IFID_Valid), .StallCount(StallCount), .FlushCount(FlushCount)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] cnt(input int v);
`ifdef IF_PERF_CNT_EN
      return 16'(v);
`else
      return (v == 0) ? 16'h0 : 16'h0;
`endif
   endfunction

   // advance one clock; outputs sampled 1 time unit after the edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic rdy, input logic [15:0] d, input logic fpc,
                        input logic fid, input logic br, input logic [15:0] tgt);
      IMem_Ready = rdy; IMem_Data = d; FrezePC = fpc; FrezeIFID = fid;
      BranchTaken = br; BranchTarget = tgt;
   endtask

   initial begin
      rest = 1'b1;
      drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0);
      step(); step();
      chk("rst_req", {15'b0, IMem_Req}, 16'h0);
      chk("rst_addr", IMem_Addr, 16'h0000);
      chk("rst_valid", {15'b0, IFID_Valid}, 16'h0);
      chk("rst_instr", IFID_Instr, 16'h0000);
      chk("rst_stallcnt", StallCount, 16'h0);
      chk("rst_flushcnt", FlushCount, 16'h0);

      // sequential fetch
      rest = 1'b0;
      #1;
      chk("fetch0_req", {15'b0, IMem_Req}, 16'h1);
      chk("fetch0_addr", IMem_Addr, 16'h0000);
      drive(1'b1, 16'h1111, 1'b0, 1'b0, 1'b0, 16'h0);
      step();
      chk("f1_instr", IFID_Instr, 16'h1111);
      chk("f1_pc", IFID_PC, 16'h0001);
      chk("f1_valid", {15'b0, IFID_Valid}, 16'h1);
      chk("f1_addr", IMem_Addr, 16'h0001);
      IMem_Data = 16'h2222;
      step();
      chk("f2_instr", IFID_Instr, 16'h2222);
      chk("f2_pc", IFID_PC, 16'h0002);
      chk("f2_addr", IMem_Addr, 16'h0002);
      IMem_Data = 16'h3333; step();
      IMem_Data = 16'h4444; step();
      IMem_Data = 16'h5555; step();
      chk("f5_addr", IMem_Addr, 16'h0005);

      // stalled fetch parks the word
      drive(1'b1, 16'hABCD, 1'b1, 1'b0, 1'b0, 16'h0);
      step();
      chk("hold_req", {15'b0, IMem_Req}, 16'h0);
      chk("hold_addr", IMem_Addr, 16'h0005);
      chk("hold_instr", IFID_Instr, 16'h5555);
      chk("hold_ifidpc", IFID_PC, 16'h0005);
      drive(1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 16'h0);
      step(); step();
      chk("hold3_req", {15'b0, IMem_Req}, 16'h0);
      chk("hold3_instr", IFID_Instr, 16'h5555);
      drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0);
      step();
      chk("rel_instr", IFID_Instr, 16'hABCD);
      chk("rel_ifidpc", IFID_PC, 16'h0006);
      chk("rel_addr", IMem_Addr, 16'h0006);
      chk("rel_req", {15'b0, IMem_Req}, 16'h1);
      chk("rel_stallcnt", StallCount, cnt(3));

      // two bubbles
      step();
      chk("bub1_valid", {15'b0, IFID_Valid}, 16'h0);
      chk("bub1_instr", IFID_Instr, 16'h0000);
      step();
      chk("bub2_valid", {15'b0, IFID_Valid}, 16'h0);
      chk("bub2_addr", IMem_Addr, 16'h0006);

      // branch beats ready and stall
      drive(1'b1, 16'h7777, 1'b1, 1'b0, 1'b1, 16'h0040);
      step();
      chk("br_addr", IMem_Addr, 16'h0040);
      chk("br_valid", {15'b0, IFID_Valid}, 16'h0);
      chk("br_instr", IFID_Instr, 16'h0000);
      chk("br_req", {15'b0, IMem_Req}, 16'h1);
      chk("br_flushcnt", FlushCount, cnt(1));
      chk("br_stallcnt", StallCount, cnt(3));
      drive(1'b1, 16'h8888, 1'b0, 1'b0, 1'b0, 16'h0);
      step();
      chk("br_next_instr", IFID_Instr, 16'h8888);
      chk("br_next_pc", IFID_PC, 16'h0041);

      // wrap at 16'hFFFF
      drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 16'hFFFF);
      step();
      chk("wrap_addr0", IMem_Addr, 16'hFFFF);
      drive(1'b1, 16'h9999, 1'b0, 1'b0, 1'b0, 16'h0);
      step();
      chk("wrap_instr", IFID_Instr, 16'h9999);
      chk("wrap_ifidpc", IFID_PC, 16'h0000);
      chk("wrap_addr", IMem_Addr, 16'h0000);

      // branch while holding discards the parked word
      drive(1'b1, 16'hAAAA, 1'b1, 1'b0, 1'b0, 16'h0);
      step();
      chk("hb_req", {15'b0, IMem_Req}, 16'h0);
      drive(1'b0, 16'h0, 1'b1, 1'b0, 1'b1, 16'h0010);
      step();
      chk("hb_addr", IMem_Addr, 16'h0010);
      chk("hb_req2", {15'b0, IMem_Req}, 16'h1);
      chk("hb_flushcnt", FlushCount, cnt(3));
      drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0);
      step();
      chk("hb_bubble", {15'b0, IFID_Valid}, 16'h0);
      chk("hb_addr2", IMem_Addr, 16'h0010);

      // no-ready stall holds IF/ID
      drive(1'b1, 16'h1234, 1'b0, 1'b0, 1'b0, 16'h0);
      step();
      drive(1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 16'h0);
      step();
      chk("nr_valid", {15'b0, IFID_Valid}, 16'h1);
      chk("nr_instr", IFID_Instr, 16'h1234);
      chk("nr_addr", IMem_Addr, 16'h0011);
      chk("nr_stallcnt", StallCount, cnt(5));

      // reset in HOLD
      drive(1'b1, 16'h5678, 1'b1, 1'b0, 1'b0, 16'h0);
      step();
      chk("rh_req", {15'b0, IMem_Req}, 16'h0);
      rest = 1'b1;
      step();
      chk("rh_addr", IMem_Addr, 16'h0000);
      chk("rh_valid", {15'b0, IFID_Valid}, 16'h0);
      chk("rh_req2", {15'b0, IMem_Req}, 16'h0);
      chk("rh_stallcnt", StallCount, 16'h0);
      chk("rh_flushcnt", FlushCount, 16'h0);
      rest = 1'b0;
      drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0);
      #1;
      chk("rh_req3", {15'b0, IMem_Req}, 16'h1);
      step();
      chk("rh_bubble", {15'b0, IFID_Valid}, 16'h0);
      chk("rh_addr2", IMem_Addr, 16'h0000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have port clk  input  1  single rising-edge clock for all state.
REQ-002 SHALL have port rest  input  1  synchronous active-high reset, sampled on the rising edge of clk.
REQ-003 SHALL have port FrezePC  input  1  hazard unit request to hold the PC.
REQ-004 SHALL have port FrezeIFID  input  1  hazard unit request to hold the IF/ID register.
REQ-005 SHALL have port BranchTaken  input  1  redirect request from the EX stage.
REQ-006 SHALL have port BranchTarget  input  16  redirect address.
REQ-007 SHALL have port IMem_Req  output  1  instruction memory fetch request.
REQ-008 SHALL have port IMem_Addr  output  16  fetch address, equal to the PC.
REQ-009 SHALL have port IMem_Ready  input  1  instruction memory data-valid strobe.
REQ-010 SHALL have port IMem_Data  input  16  fetched instruction.
REQ-011 SHALL have port IFID_Instr  output  16  IF/ID instruction; NOP is 16'h0000.
REQ-012 SHALL have port IFID_PC  output  16  IF/ID copy of PC+1 for the held instruction.
REQ-013 SHALL have port IFID_Valid  output  1  IF/ID holds a real instruction.
REQ-014 SHALL have port StallCount  output  16  stall-cycle counter (see Configuration).
REQ-015 SHALL have port FlushCount  output  16  flush counter (see Configuration).

Function
REQ-016 SHALL define Stall = FrezePC OR FrezeIFID; both freeze inputs act as one hold.
REQ-017 SHALL implement states FETCH (IMem_Req=1) and HOLD (IMem_Req=0, fetched word parked in a 16-bit buffer).
REQ-018 SHALL drive IMem_Addr = PC combinationally in every state.
REQ-019 In FETCH with IMem_Ready=1 and Stall=0, SHALL load IFID_Instr=IMem_Data, IFID_PC=PC+1, IFID_Valid=1, PC<=PC+1, remain in FETCH.
REQ-020 In FETCH with IMem_Ready=1 and Stall=1, SHALL park IMem_Data in the buffer, hold PC and IF/ID, and go to HOLD.
REQ-021 In FETCH with IMem_Ready=0 and Stall=0, SHALL load a bubble (IFID_Valid=0, IFID_Instr=16'h0000) and hold PC.
REQ-022 In FETCH with IMem_Ready=0 and Stall=1, SHALL hold PC and IF/ID unchanged.
REQ-023 In HOLD with Stall=1, SHALL hold PC, IF/ID and buffer.
REQ-024 In HOLD with Stall=0, SHALL load IF/ID from the buffer (IFID_PC=PC+1, IFID_Valid=1), set PC<=PC+1, and go to FETCH.
REQ-025 BranchTaken=1 SHALL take priority over Stall and IMem_Ready: PC<=BranchTarget, IFID_Valid<=0, IFID_Instr<=16'h0000, discard any same-cycle or buffered word, go to FETCH.
REQ-026 PC+1 SHALL wrap modulo 2^16 (16'hFFFF -> 16'h0000).
REQ-027 Latency from IMem_Ready (Stall=0) to IFID_Valid SHALL be one clock.
REQ-028 An instruction SHALL never be duplicated or dropped except by a BranchTaken flush.

Reset
REQ-029 While rest=1, SHALL set PC=16'h0000, state=FETCH, IFID_Instr=16'h0000, IFID_PC=16'h0000, IFID_Valid=0, buffer=16'h0000, and both counters to 0, overriding all other inputs.
REQ-030 SHALL hold IMem_Req=0 during any cycle in which rest=1; fetch of address 0 starts the cycle after rest falls.
REQ-031 Reset mid-HOLD SHALL discard the parked word.

Configuration
REQ-032 With IF_PERF_CNT_EN defined, StallCount SHALL increment once per cycle with Stall=1 and BranchTaken=0, and FlushCount once per cycle with BranchTaken=1; both saturate at 16'hFFFF.
REQ-033 Without IF_PERF_CNT_EN, StallCount and FlushCount SHALL be constant 16'h0000, and no counter flops SHALL be synthesized.

Verification
REQ-034 Reset release, then IMem_Ready=1 each cycle with data 16'h1111,16'h2222 -> IMem_Addr 0,1,2; IFID_Instr 16'h1111 with IFID_PC=1, then 16'h2222 with IFID_PC=2.
REQ-035 FETCH at PC=5 with IMem_Ready=1, data 16'hABCD, Stall=1 for 3 cycles -> state HOLD, IMem_Req=0, PC=5, IF/ID unchanged; on release IFID_Instr=16'hABCD, IFID_PC=6, PC=6.
REQ-036 BranchTaken=1, BranchTarget=16'h0040, same cycle as IMem_Ready=1 and Stall=1 -> PC=16'h0040, IFID_Valid=0, word dropped, FlushCount +1 (macro on).
REQ-037 PC=16'hFFFF, IMem_Ready=1, Stall=0 -> IFID_PC=16'h0000, next IMem_Addr=16'h0000.
REQ-038 IMem_Ready=0 for 2 cycles with Stall=0 -> two bubbles (IFID_Valid=0, IFID_Instr=16'h0000), PC held.
REQ-039 Assert rest while in HOLD -> next cycle PC=0, IFID_Valid=0, IMem_Req=0, counters 0.
